// File: rtl/spring_controller_pkg.sv
// Shared types and default geometry/gain constants for the launch spring.
package spring_controller_pkg;

  typedef enum logic [1:0] {IDLE, COMPRESS, RELEASE} spring_state_t;

  localparam int unsigned COMP_W   = 6;
  localparam int unsigned Y_W      = 11;
  localparam int unsigned SPEED_W  = 32;
  localparam int unsigned AF_CNT_W = 7;

  localparam int SPRING_REST_Y           = 400;
  localparam int SPRING_MAX_COMPRESS     = 32;
  localparam int SPRING_COMPRESS_STEP    = 1;
  localparam int SPRING_RELEASE_STEP     = 8;
  localparam int SPRING_SPEED_GAIN       = 16;
  localparam int SPRING_AUTO_FIRE_FRAMES = 60;

endpackage

// File: rtl/spring_controller_if.sv
// Frame/key/collision inputs and ball-controller/drawing outputs of the spring.
interface spring_controller_if;
  import spring_controller_pkg::*;

  logic                      startOfFrame;
  logic                      keyIsPressed;
  logic                      pause;
  logic                      reset_level;
  logic                      collisionSmileySpring;
  logic signed [Y_W-1:0]     springTopY;
  logic signed [SPEED_W-1:0] springSpeedY;
  logic                      collisionSmileySpringPulse;
  logic [COMP_W-1:0]         springCompression;

  modport master (
    output startOfFrame, keyIsPressed, pause, reset_level, collisionSmileySpring,
    input  springTopY, springSpeedY, collisionSmileySpringPulse, springCompression
  );

  modport slave (
    input  startOfFrame, keyIsPressed, pause, reset_level, collisionSmileySpring,
    output springTopY, springSpeedY, collisionSmileySpringPulse, springCompression
  );
endinterface

// File: rtl/frame_pulse_latch.sv
// Turns an overlap level into at most one registered one-clk pulse per frame.
module frame_pulse_latch (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic hold,
  input  logic frame_tick,
  input  logic level,
  output logic pulse
);

  logic hit_q, hit_d;
  logic pulse_q, pulse_d;
  logic hit_eff;

  // A frame tick re-arms the latch in the same cycle it arrives.
  assign hit_eff = hit_q && !frame_tick;

  always_comb begin
    hit_d   = hit_q;
    pulse_d = 1'b0;
    if (clear) begin
      hit_d = 1'b0;
    end else if (!hold) begin
      hit_d = hit_eff;
      if (level && !hit_eff) begin
        hit_d   = 1'b1;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      hit_q   <= hit_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/spring_controller.sv
// Launch spring: frame-stepped compress/release FSM, launch speed and collision pulse.
// Optional SPRING_AUTO_FIRE_EN forces release after a hold at full compression.
module spring_controller #(
  parameter int SPRING_REST_Y    = spring_controller_pkg::SPRING_REST_Y,
  parameter int MAX_COMPRESS     = spring_controller_pkg::SPRING_MAX_COMPRESS,
  parameter int COMPRESS_STEP    = spring_controller_pkg::SPRING_COMPRESS_STEP,
  parameter int RELEASE_STEP     = spring_controller_pkg::SPRING_RELEASE_STEP,
  parameter int SPEED_GAIN       = spring_controller_pkg::SPRING_SPEED_GAIN
`ifdef SPRING_AUTO_FIRE_EN
  ,
  parameter int AUTO_FIRE_FRAMES = spring_controller_pkg::SPRING_AUTO_FIRE_FRAMES
`endif
) (
  input logic               clk,
  input logic               resetN,
  spring_controller_if.slave bus
);
  import spring_controller_pkg::*;

  spring_state_t              state_q, state_d;
  logic [COMP_W-1:0]          comp_q, comp_d;
  logic signed [SPEED_W-1:0]  launch_q, launch_d;
  logic signed [SPEED_W-1:0]  speed_q, speed_d;
  logic                       fire;
  int                         comp_up;
  int                         comp_dn;
`ifdef SPRING_AUTO_FIRE_EN
  logic [AF_CNT_W-1:0]        cnt_q, cnt_d;
  logic                       block_q, block_d;
`endif

  // Next-state: reset_level beats pause, which beats normal frame stepping.
  always_comb begin
    state_d  = state_q;
    comp_d   = comp_q;
    launch_d = launch_q;
    speed_d  = speed_q;
    fire     = 1'b0;
    comp_up  = int'(comp_q) + COMPRESS_STEP;
    comp_dn  = int'(comp_q) - RELEASE_STEP;
`ifdef SPRING_AUTO_FIRE_EN
    cnt_d    = cnt_q;
    block_d  = block_q;
`endif
    if (bus.reset_level) begin
      state_d  = IDLE;
      comp_d   = '0;
      launch_d = '0;
      speed_d  = '0;
`ifdef SPRING_AUTO_FIRE_EN
      cnt_d    = '0;
      block_d  = 1'b0;
`endif
    end else if (!bus.pause) begin
      speed_d = (state_q == RELEASE) ? launch_q : '0;
      if (bus.startOfFrame) begin
`ifdef SPRING_AUTO_FIRE_EN
        if (!bus.keyIsPressed) block_d = 1'b0;
`endif
        case (state_q)
          IDLE: begin
`ifdef SPRING_AUTO_FIRE_EN
            if (bus.keyIsPressed && !block_q) begin
`else
            if (bus.keyIsPressed) begin
`endif
              state_d = COMPRESS;
              comp_d  = COMP_W'(COMPRESS_STEP);
            end
          end
          COMPRESS: begin
            fire = !bus.keyIsPressed;
`ifdef SPRING_AUTO_FIRE_EN
            if (comp_q == COMP_W'(MAX_COMPRESS)) begin
              cnt_d = cnt_q + AF_CNT_W'(1);
              if (cnt_q == AF_CNT_W'(AUTO_FIRE_FRAMES - 1)) begin
                fire    = 1'b1;
                block_d = bus.keyIsPressed;
              end
            end
`endif
            if (fire) begin
              state_d  = RELEASE;
              launch_d = -(int'(comp_q) * SPEED_GAIN);
`ifdef SPRING_AUTO_FIRE_EN
              cnt_d    = '0;
`endif
            end else if (comp_up >= MAX_COMPRESS) begin
              comp_d = COMP_W'(MAX_COMPRESS);
            end else begin
              comp_d = COMP_W'(comp_up);
            end
          end
          RELEASE: begin
            if (comp_dn <= 0) begin
              comp_d   = '0;
              state_d  = IDLE;
              launch_d = '0;
            end else begin
              comp_d = COMP_W'(comp_dn);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      comp_q   <= '0;
      launch_q <= '0;
      speed_q  <= '0;
`ifdef SPRING_AUTO_FIRE_EN
      cnt_q    <= '0;
      block_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      comp_q   <= comp_d;
      launch_q <= launch_d;
      speed_q  <= speed_d;
`ifdef SPRING_AUTO_FIRE_EN
      cnt_q    <= cnt_d;
      block_q  <= block_d;
`endif
    end
  end

  frame_pulse_latch u_pulse (
    .clk        (clk),
    .resetN     (resetN),
    .clear      (bus.reset_level),
    .hold       (bus.pause),
    .frame_tick (bus.startOfFrame),
    .level      (bus.collisionSmileySpring),
    .pulse      (bus.collisionSmileySpringPulse)
  );

  assign bus.springTopY        = Y_W'(SPRING_REST_Y + int'(comp_q));
  assign bus.springSpeedY      = speed_q;
  assign bus.springCompression = comp_q;

endmodule

// File: tb/tb_spring_controller.sv
// Directed self-checking bench for spring_controller with hand-computed expectations.
module tb_spring_controller;

  logic clk;
  logic resetN;
  int   checks;
  int   errors;
  int   pulses;

  spring_controller_if bus ();

  spring_controller dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive frame tick, advance to the next falling edge, count pulses.
  task automatic cyc(input logic s);
    bus.startOfFrame = s;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    if (bus.collisionSmileySpringPulse === 1'b1) pulses++;
  endtask

  task automatic frame(input logic k);
    bus.keyIsPressed = k;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
  endtask

  task automatic frames(input int n, input logic k);
    for (int i = 0; i < n; i++) frame(k);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulses = 0;
    resetN = 1'b0;
    bus.startOfFrame          = 1'b0;
    bus.keyIsPressed          = 1'b0;
    bus.pause                 = 1'b0;
    bus.reset_level           = 1'b0;
    bus.collisionSmileySpring = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_topY", 32'(bus.springTopY), 400);
    chk("rst_speed", bus.springSpeedY, 0);
    chk("rst_comp", 32'(bus.springCompression), 0);
    chk("rst_pulse", 32'(bus.collisionSmileySpringPulse), 0);
    resetN = 1'b1;
    @(negedge clk);

    // Five frames of compression, then release.
    frames(5, 1'b1);
    chk("c5_comp", 32'(bus.springCompression), 5);
    chk("c5_topY", 32'(bus.springTopY), 405);
    chk("c5_speed", bus.springSpeedY, 0);
    bus.keyIsPressed = 1'b0;
    cyc(1'b1);
    chk("c5_speed_latency", bus.springSpeedY, 0);
    cyc(1'b0);
    chk("c5_speed_rel", bus.springSpeedY, -80);
    cyc(1'b0);
    cyc(1'b0);
    chk("c5_comp_rel", 32'(bus.springCompression), 5);
    frame(1'b0);
    chk("c5_comp_done", 32'(bus.springCompression), 0);
    chk("c5_speed_done", bus.springSpeedY, 0);

    // Saturation at 32, then a four-frame release at -512.
    frames(40, 1'b1);
    chk("sat_comp", 32'(bus.springCompression), 32);
    chk("sat_topY", 32'(bus.springTopY), 432);
    frame(1'b0);
    chk("sat_speed", bus.springSpeedY, -512);
    frame(1'b1);
    chk("rel_comp24", 32'(bus.springCompression), 24);
    chk("rel_speed24", bus.springSpeedY, -512);
    frame(1'b1);
    chk("rel_comp16", 32'(bus.springCompression), 16);
    frame(1'b0);
    chk("rel_comp8", 32'(bus.springCompression), 8);
    chk("rel_speed8", bus.springSpeedY, -512);
    frame(1'b0);
    chk("rel_comp0", 32'(bus.springCompression), 0);
    chk("rel_speed0", bus.springSpeedY, 0);

    // Collision held across three frames: one pulse per frame.
    pulses = 0;
    bus.collisionSmileySpring = 1'b1;
    cyc(1'b0);
    chk("pulse_first", 32'(bus.collisionSmileySpringPulse), 1);
    cyc(1'b0);
    chk("pulse_single", 32'(bus.collisionSmileySpringPulse), 0);
    cyc(1'b0);
    cyc(1'b1);
    chk("pulse_frame2", 32'(bus.collisionSmileySpringPulse), 1);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    bus.collisionSmileySpring = 1'b0;
    cyc(1'b0);
    chk("pulse_count3", pulses, 3);

    // Pause suppresses pulses.
    pulses = 0;
    bus.pause = 1'b1;
    bus.collisionSmileySpring = 1'b1;
    frames(2, 1'b0);
    chk("pause_pulses", pulses, 0);
    bus.pause = 1'b0;
    bus.collisionSmileySpring = 1'b0;
    cyc(1'b0);

    // reset_level mid-release wins over a coincident frame tick.
    frames(35, 1'b1);
    frame(1'b0);
    chk("rl_speed_before", bus.springSpeedY, -512);
    bus.keyIsPressed = 1'b1;
    bus.reset_level  = 1'b1;
    cyc(1'b1);
    bus.reset_level  = 1'b0;
    chk("rl_speed", bus.springSpeedY, 0);
    chk("rl_topY", 32'(bus.springTopY), 400);
    chk("rl_comp", 32'(bus.springCompression), 0);
    cyc(1'b0);
    cyc(1'b0);
    frame(1'b1);
    chk("rl_idle_restart", 32'(bus.springCompression), 1);

    // Pause at compression 16 with key held.
    frames(15, 1'b1);
    chk("pz_comp16", 32'(bus.springCompression), 16);
    bus.pause = 1'b1;
    frames(10, 1'b1);
    chk("pz_hold16", 32'(bus.springCompression), 16);
    bus.pause = 1'b0;
    frame(1'b1);
    chk("pz_resume17", 32'(bus.springCompression), 17);
    frame(1'b1);
    chk("pz_resume18", 32'(bus.springCompression), 18);

    // Pause during release holds compression and speed.
    frames(14, 1'b1);
    frame(1'b0);
    frame(1'b0);
    chk("pr_comp24", 32'(bus.springCompression), 24);
    bus.pause = 1'b1;
    frames(3, 1'b0);
    chk("pr_hold_comp", 32'(bus.springCompression), 24);
    chk("pr_hold_speed", bus.springSpeedY, -512);
    bus.pause = 1'b0;
    frames(3, 1'b0);
    chk("pr_done_comp", 32'(bus.springCompression), 0);
    chk("pr_done_speed", bus.springSpeedY, 0);

    // Long hold at full compression.
    frames(32, 1'b1);
    chk("hold_comp32", 32'(bus.springCompression), 32);
`ifdef SPRING_AUTO_FIRE_EN
    frames(59, 1'b1);
    chk("af_still32", 32'(bus.springCompression), 32);
    chk("af_no_speed", bus.springSpeedY, 0);
    frame(1'b1);
    chk("af_fire_speed", bus.springSpeedY, -512);
    frames(4, 1'b1);
    chk("af_rel_done", 32'(bus.springCompression), 0);
    frame(1'b1);
    chk("af_blocked", 32'(bus.springCompression), 0);
    frame(1'b0);
    frame(1'b1);
    chk("af_rearm", 32'(bus.springCompression), 1);
`else
    frames(70, 1'b1);
    chk("nofire_comp", 32'(bus.springCompression), 32);
    chk("nofire_speed", bus.springSpeedY, 0);
    frame(1'b0);
    chk("nofire_release", bus.springSpeedY, -512);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
